// File: rtl/data_mover_bram_nc.sv
// data_mover_bram_nc: streams N words from BRAM0 port A through NUM_CORE
// parallel lane cores and writes the packed results to BRAM1 port A at the
// same address, one word per clock.
//
// Ports:
//   clk, reset_n             clock, asynchronous active-low reset
//   i_run, i_num_cnt, i_mode start pulse (IDLE only), word count, op select
//                            (00 umul, 01 uadd, 10 smul, 11 copy)
//   o_idle, o_read, o_write, o_done   status / one-cycle completion pulse
//   addr_b0, ce_b0, we_b0, q_b0, d_b0  BRAM0 port A (read only)
//   addr_b1, ce_b1, we_b1, q_b1, d_b1  BRAM1 port A (write only)
//   o_checksum               sum of written words (DATA_MOVER_CHECKSUM_EN only)
//
// Optional feature: define DATA_MOVER_CHECKSUM_EN to add o_checksum.
module data_mover_bram_nc #(
    parameter int unsigned CNT_BIT       = 31,
    parameter int unsigned DWIDTH        = 32,
    parameter int unsigned AWIDTH        = 21,
    parameter int unsigned MEM_SIZE      = 8192,
    parameter int unsigned IN_DATA_WIDTH = 8,
    parameter int unsigned NUM_CORE      = 2,
    parameter int unsigned RD_LATENCY    = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               i_run,
    input  logic [CNT_BIT-1:0] i_num_cnt,
    input  logic [1:0]         i_mode,
    output logic               o_idle,
    output logic               o_read,
    output logic               o_write,
    output logic               o_done,
    output logic [AWIDTH-1:0]  addr_b0,
    output logic               ce_b0,
    output logic               we_b0,
    input  logic [DWIDTH-1:0]  q_b0,
    output logic [DWIDTH-1:0]  d_b0,
    output logic [AWIDTH-1:0]  addr_b1,
    output logic               ce_b1,
    output logic               we_b1,
    input  logic [DWIDTH-1:0]  q_b1,
    output logic [DWIDTH-1:0]  d_b1
`ifdef DATA_MOVER_CHECKSUM_EN
    ,
    output logic [31:0]        o_checksum
`endif
);

    localparam int unsigned IW = IN_DATA_WIDTH;
    localparam int unsigned PW = 2 * IN_DATA_WIDTH;
    localparam int unsigned RW = DWIDTH / NUM_CORE;

    // Elaboration-time parameter sanity checks
    if (DWIDTH != 2 * NUM_CORE * IN_DATA_WIDTH) begin : g_bad_width
        $error("data_mover_bram_nc: DWIDTH must equal 2*NUM_CORE*IN_DATA_WIDTH");
    end
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
        $error("data_mover_bram_nc: RD_LATENCY must be in 1..4");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_BIT-1:0]    n_lat;
    logic [1:0]            mode_lat;
    logic [CNT_BIT-1:0]    rd_cnt;
    logic [CNT_BIT-1:0]    wr_cnt;
    logic [RD_LATENCY-1:0] vld_pipe;
    logic                  res_vld;
    logic [DWIDTH-1:0]     res_q;
    logic [DWIDTH-1:0]     core_res;
    logic [CNT_BIT-1:0]    n_in;
    logic                  start_c;
    logic                  rd_active_c;

    // Effective count, clamped to the memory depth
    assign n_in    = (i_num_cnt > CNT_BIT'(MEM_SIZE)) ? CNT_BIT'(MEM_SIZE) : i_num_cnt;
    assign start_c = (state == S_IDLE) && i_run;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state and decoded controls
    always_comb begin
        state_nxt   = state;
        o_idle      = 1'b0;
        o_done      = 1'b0;
        rd_active_c = 1'b0;
        case (state)
            S_IDLE: begin
                o_idle = 1'b1;
                if (i_run) state_nxt = (n_in == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                rd_active_c = (rd_cnt < n_lat);
                if (res_vld && (wr_cnt == n_lat - CNT_BIT'(1))) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_done    = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Counters, read-valid pipe and result register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_lat    <= '0;
            mode_lat <= '0;
            rd_cnt   <= '0;
            wr_cnt   <= '0;
            vld_pipe <= '0;
            res_vld  <= 1'b0;
            res_q    <= '0;
        end else begin
            if (start_c) begin
                n_lat    <= n_in;
                mode_lat <= i_mode;
                rd_cnt   <= '0;
                wr_cnt   <= '0;
            end else begin
                if (rd_active_c) rd_cnt <= rd_cnt + CNT_BIT'(1);
                if (res_vld)     wr_cnt <= wr_cnt + CNT_BIT'(1);
            end
            // vld_pipe[RD_LATENCY-1] is high in the cycle q_b0 holds valid data
            vld_pipe[0] <= rd_active_c;
            for (int i = 1; i < RD_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
            res_vld <= vld_pipe[RD_LATENCY-1];
            if (vld_pipe[RD_LATENCY-1]) res_q <= core_res;
        end
    end

    // Lane cores: core k takes lanes 2k / 2k+1 (MSB first), result slot k
    for (genvar k = 0; k < NUM_CORE; k++) begin : g_core
        logic [IW-1:0] a;
        logic [IW-1:0] b;
        logic [PW-1:0] a_sx;
        logic [PW-1:0] b_sx;
        logic [PW-1:0] prod_u;
        logic [PW-1:0] prod_s;
        logic [IW:0]   sum;
        logic [RW-1:0] r;

        assign a      = q_b0[DWIDTH-1-(2*k)*IW -: IW];
        assign b      = q_b0[DWIDTH-1-(2*k+1)*IW -: IW];
        assign a_sx   = {{IW{a[IW-1]}}, a};
        assign b_sx   = {{IW{b[IW-1]}}, b};
        assign prod_u = PW'(a) * PW'(b);
        // Low PW bits of the sign-extended product are the exact signed product
        assign prod_s = a_sx * b_sx;
        assign sum    = (IW+1)'(a) + (IW+1)'(b);

        always_comb begin
            r = '0;
            case (mode_lat)
                2'b00:   r = RW'(prod_u);
                2'b01:   r = RW'(sum);
                2'b10:   r = RW'($signed(prod_s));
                default: r = q_b0[DWIDTH-1-k*RW -: RW];
            endcase
        end

        assign core_res[DWIDTH-1-k*RW -: RW] = r;
    end

    assign o_read  = rd_active_c;
    assign ce_b0   = rd_active_c;
    assign addr_b0 = AWIDTH'(rd_cnt);
    assign we_b0   = 1'b0;
    assign d_b0    = '0;

    assign o_write = res_vld;
    assign ce_b1   = res_vld;
    assign we_b1   = res_vld;
    assign addr_b1 = AWIDTH'(wr_cnt);
    assign d_b1    = res_q;

    // BRAM1 read data is not used by the mover
    logic unused_q_b1;
    assign unused_q_b1 = ^q_b1;

`ifdef DATA_MOVER_CHECKSUM_EN
    // Running modulo-2^32 sum of written words; cleared when a run starts
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            o_checksum <= '0;
        end else if (start_c && (n_in != '0)) begin
            o_checksum <= '0;
        end else if (res_vld) begin
            o_checksum <= o_checksum + 32'(res_q);
        end
    end
`endif

endmodule

// File: tb/tb_data_mover_bram_nc.sv
module tb_data_mover_bram_nc;

    localparam int MEM = 8192;
    localparam logic [31:0] SENT = 32'hDEAD_BEEF;

    logic        clk;
    logic        reset_n;
    logic        i_run;
    logic [30:0] i_num_cnt;
    logic [1:0]  i_mode;
    logic        o_idle, o_read, o_write, o_done;
    logic [20:0] addr_b0, addr_b1;
    logic        ce_b0, we_b0, ce_b1, we_b1;
    logic [31:0] q_b0, d_b0, q_b1, d_b1;
`ifdef DATA_MOVER_CHECKSUM_EN
    logic [31:0] o_checksum;
`endif

    data_mover_bram_nc dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_run     (i_run),
        .i_num_cnt (i_num_cnt),
        .i_mode    (i_mode),
        .o_idle    (o_idle),
        .o_read    (o_read),
        .o_write   (o_write),
        .o_done    (o_done),
        .addr_b0   (addr_b0),
        .ce_b0     (ce_b0),
        .we_b0     (we_b0),
        .q_b0      (q_b0),
        .d_b0      (d_b0),
        .addr_b1   (addr_b1),
        .ce_b1     (ce_b1),
        .we_b1     (we_b1),
        .q_b1      (q_b1),
        .d_b1      (d_b1)
`ifdef DATA_MOVER_CHECKSUM_EN
        ,
        .o_checksum(o_checksum)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM models: BRAM0 one-cycle read, BRAM1 write port
    logic [31:0] mem0 [MEM];
    logic [31:0] mem1 [MEM];
    logic        mem1_clr;

    always @(posedge clk) begin
        if (ce_b0) q_b0 <= mem0[addr_b0[12:0]];
    end

    always @(posedge clk) begin
        if (mem1_clr) begin
            for (int i = 0; i < MEM; i++) mem1[i] <= SENT;
        end else if (ce_b1 && we_b1) begin
            mem1[addr_b1[12:0]] <= d_b1;
        end
    end

    assign q_b1 = 32'h0;

    // Activity monitors
    int rd_seen, wr_seen, done_seen;
    initial begin
        rd_seen = 0; wr_seen = 0; done_seen = 0;
    end
    always @(negedge clk) begin
        if (ce_b0) rd_seen <= rd_seen + 1;
        if (ce_b1) wr_seen <= wr_seen + 1;
        if (o_done) done_seen <= done_seen + 1;
    end

    int checks, errors;

    task automatic check(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] ramp_in(input int i);
        logic [7:0] v;
        v = 8'(i & 32'h7F);
        return {v, v, v, v};
    endfunction

    function automatic logic [31:0] ramp_exp(input int i);
        logic [15:0] p;
        p = 16'(i & 32'h7F) * 16'(i & 32'h7F);
        return {p, p};
    endfunction

    task automatic load_mem0(input bit ramp, input logic [31:0] word);
        for (int i = 0; i < MEM; i++) mem0[i] = ramp ? ramp_in(i) : word;
    endtask

    task automatic clear_mem1();
        @(negedge clk); mem1_clr = 1'b1;
        @(negedge clk); mem1_clr = 1'b0;
    endtask

    // Start a job, optionally pulse i_run at cycle pulse_at, wait for o_done.
    // Cycle 0 is the first cycle after the start edge.
    task automatic run_job(input logic [30:0] n, input logic [1:0] mode, input int pulse_at,
                           output int done_cyc, output int rd_d, output int wr_d, output int dn_d);
        int r0, w0, d0;
        @(negedge clk);
        r0 = rd_seen; w0 = wr_seen; d0 = done_seen;
        i_num_cnt = n; i_mode = mode; i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        done_cyc = -1;
        for (int c = 0; c < 12000; c++) begin
            i_run = (c == pulse_at);
            if (o_done && done_cyc < 0) done_cyc = c;
            if (done_cyc >= 0 && c > done_cyc + 3) break;
            @(negedge clk);
        end
        i_run = 1'b0;
        rd_d = rd_seen - r0;
        wr_d = wr_seen - w0;
        dn_d = done_seen - d0;
    endtask

    task automatic check_mem1(input string nm, input int n, input bit ramp, input logic [31:0] exp_word);
        int bad;
        int first;
        bad = 0; first = -1;
        for (int i = 0; i < n; i++) begin
            if (mem1[i] !== (ramp ? ramp_exp(i) : exp_word)) begin
                bad++;
                if (first < 0) first = i;
            end
        end
        if (bad != 0)
            $display("  %s: first bad word %0d = %h", nm, first, mem1[first]);
        check({nm, " bad words"}, bad, 0);
        if (n < MEM) check({nm, " no overrun"}, mem1[n], SENT);
    endtask

    typedef struct {
        logic [30:0] n;
        logic [1:0]  mode;
        bit          ramp;
        logic [31:0] word;
        logic [31:0] exp_word;
        int          exp_n;
    } vec_t;

    localparam int NV = 9;
    vec_t vecs [NV];

    initial begin
        int dc, rd, wr, dn;
        string nm;

        vecs[0] = '{n: 31'd8192,  mode: 2'b00, ramp: 1'b1, word: 32'h0,         exp_word: 32'h0,         exp_n: 8192};
        vecs[1] = '{n: 31'd16,    mode: 2'b01, ramp: 1'b0, word: 32'hFF01_80FF, exp_word: 32'h0100_017F, exp_n: 16};
        vecs[2] = '{n: 31'd16,    mode: 2'b10, ramp: 1'b0, word: 32'hFF02_7F81, exp_word: 32'hFFFE_C0FF, exp_n: 16};
        vecs[3] = '{n: 31'd16,    mode: 2'b11, ramp: 1'b0, word: 32'hFF02_7F81, exp_word: 32'hFF02_7F81, exp_n: 16};
        vecs[4] = '{n: 31'd0,     mode: 2'b00, ramp: 1'b0, word: 32'h0102_0304, exp_word: 32'h0002_000C, exp_n: 0};
        vecs[5] = '{n: 31'd1,     mode: 2'b00, ramp: 1'b0, word: 32'h0102_0304, exp_word: 32'h0002_000C, exp_n: 1};
        vecs[6] = '{n: 31'd10000, mode: 2'b01, ramp: 1'b0, word: 32'h0101_0101, exp_word: 32'h0002_0002, exp_n: 8192};
        vecs[7] = '{n: 31'd7,     mode: 2'b00, ramp: 1'b0, word: 32'hFFFF_FFFF, exp_word: 32'hFE01_FE01, exp_n: 7};
        vecs[8] = '{n: 31'd5,     mode: 2'b10, ramp: 1'b0, word: 32'h8080_8080, exp_word: 32'h4000_4000, exp_n: 5};

        checks = 0; errors = 0;
        reset_n = 1'b0; i_run = 1'b0; i_num_cnt = '0; i_mode = '0; mem1_clr = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst o_idle", o_idle, 1);
        check("rst ctrl", {o_done, o_read, o_write, ce_b0, we_b0, ce_b1, we_b1}, 0);
        check("rst addr", {addr_b0, addr_b1}, 0);
        check("rst d_b1", d_b1, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post-rst idle", o_idle, 1);

        // Table-driven runs
        for (int v = 0; v < NV; v++) begin
            load_mem0(vecs[v].ramp, vecs[v].word);
            clear_mem1();
            run_job(vecs[v].n, vecs[v].mode, -1, dc, rd, wr, dn);
            nm = $sformatf("vec%0d", v);
            check({nm, " done cycle"}, dc, (vecs[v].exp_n == 0) ? 0 : vecs[v].exp_n + 2);
            check({nm, " done pulses"}, dn, 1);
            check({nm, " reads"}, rd, vecs[v].exp_n);
            check({nm, " writes"}, wr, vecs[v].exp_n);
            check_mem1(nm, vecs[v].exp_n, vecs[v].ramp, vecs[v].exp_word);
            check({nm, " idle after"}, o_idle, 1);
        end

        // i_run pulsed during RUN is ignored
        load_mem0(1'b0, 32'h0304_0506);
        clear_mem1();
        run_job(31'd50, 2'b00, 10, dc, rd, wr, dn);
        check("ignore run done cycle", dc, 52);
        check("ignore run done pulses", dn, 1);
        check("ignore run writes", wr, 50);
        check_mem1("ignore run", 50, 1'b0, 32'h000C_001E);

        // Abort mid-run with reset, then a fresh run
        load_mem0(1'b0, 32'h0102_0304);
        @(negedge clk);
        i_num_cnt = 31'd500; i_mode = 2'b00; i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        repeat (100) @(negedge clk);
        check("pre-abort reading", ce_b0, 1);
        reset_n = 1'b0;
        #1;
        check("abort o_idle", o_idle, 1);
        check("abort ce", {ce_b0, ce_b1, we_b1}, 0);
        @(negedge clk);
        reset_n = 1'b1;
        load_mem0(1'b0, 32'hFF01_80FF);
        clear_mem1();
        run_job(31'd16, 2'b01, -1, dc, rd, wr, dn);
        check("post-abort done cycle", dc, 18);
        check("post-abort writes", wr, 16);
        check_mem1("post-abort", 16, 1'b0, 32'h0100_017F);

`ifdef DATA_MOVER_CHECKSUM_EN
        load_mem0(1'b0, 32'h0102_0304);
        clear_mem1();
        run_job(31'd4, 2'b00, -1, dc, rd, wr, dn);
        check("checksum", o_checksum, 32'h0008_0030);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
